// File: rtl/ecc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ecc_pkg
// Description : Shared definitions for the binary-field scalar multiplier.
//               Holds the default field and scalar widths, the step-unit
//               timeout and the ladder sequencer state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package ecc_pkg;

    // Default field element width and scalar width (sect233 family).
    localparam int ECC_N       = 233;
    localparam int ECC_K_W     = 233;
    localparam int ECC_CNT_W   = 8;
    localparam int ECC_TIMEOUT = 4096;

    // Ladder sequencer state encoding.
    localparam int         ST_W      = 3;
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SCAN   = 3'd1;
    localparam logic [2:0] ST_ISSUE  = 3'd2;
    localparam logic [2:0] ST_GUARD  = 3'd3;
    localparam logic [2:0] ST_WAIT   = 3'd4;
    localparam logic [2:0] ST_NEXT   = 3'd5;
    localparam logic [2:0] ST_FINISH = 3'd6;

endpackage : ecc_pkg
`default_nettype wire

// File: rtl/ladder_swap.sv
`default_nettype none
// ============================================================================
// Module      : ladder_swap
// Description : Combinational conditional swap of two projective points.
//               i_sel=1 : P=(A), Q=(B)
//               i_sel=0 : P=(B), Q=(A)
// Ports       : i_sel                 swap key (current scalar bit)
//               i_a_x, i_a_z          first input point
//               i_b_x, i_b_z          second input point
//               o_p_x, o_p_z          first output point
//               o_q_x, o_q_z          second output point
// Revision    : 1.0 - initial release
// ============================================================================
module ladder_swap #(
    parameter int W = 233
) (
    input  logic         i_sel,
    input  logic [W-1:0] i_a_x,
    input  logic [W-1:0] i_a_z,
    input  logic [W-1:0] i_b_x,
    input  logic [W-1:0] i_b_z,
    output logic [W-1:0] o_p_x,
    output logic [W-1:0] o_p_z,
    output logic [W-1:0] o_q_x,
    output logic [W-1:0] o_q_z
);

    assign o_p_x = i_sel ? i_a_x : i_b_x;
    assign o_p_z = i_sel ? i_a_z : i_b_z;
    assign o_q_x = i_sel ? i_b_x : i_a_x;
    assign o_q_z = i_sel ? i_b_z : i_a_z;

endmodule : ladder_swap
`default_nettype wire

// File: rtl/ladder_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ladder_ctrl
// Description : Montgomery-ladder sequencer for binary-field scalar
//               multiplication. Scans the scalar for its leading one, then
//               issues one add-double step per remaining bit (MSB-1 .. 0),
//               swapping operands and results according to the bit, and
//               presents the final projective pair on DOUT_*.
// Ports       : CLK, RST                     clock, sync active-high reset
//               START, DIN_K, DIN_X1..Z2     job request, scalar, initial pair
//               BUSY, DONE, ZERO, ERROR      job status
//               DOUT_X1..Z2                  working registers / final pair
//               AD_IN_VALID, AD_P1_*, AD_P2_* step request and operands
//               AD_OUT_VALID, AD_A_*, AD_D_*  step result (A=P1+P2, D=2*P2)
// Revision    : 1.0 - initial release
// ============================================================================
module ladder_ctrl
    import ecc_pkg::*;
#(
    parameter int N       = ECC_N,
    parameter int K_W     = ECC_K_W,
    parameter int CNT_W   = ECC_CNT_W,
    parameter int TIMEOUT = ECC_TIMEOUT
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           START,
    input  logic [K_W-1:0] DIN_K,
    input  logic [N-1:0]   DIN_X1,
    input  logic [N-1:0]   DIN_Z1,
    input  logic [N-1:0]   DIN_X2,
    input  logic [N-1:0]   DIN_Z2,
    output logic           BUSY,
    output logic           DONE,
    output logic           ZERO,
    output logic           ERROR,
    output logic [N-1:0]   DOUT_X1,
    output logic [N-1:0]   DOUT_Z1,
    output logic [N-1:0]   DOUT_X2,
    output logic [N-1:0]   DOUT_Z2,
    output logic           AD_IN_VALID,
    output logic [N-1:0]   AD_P1_X,
    output logic [N-1:0]   AD_P1_Z,
    output logic [N-1:0]   AD_P2_X,
    output logic [N-1:0]   AD_P2_Z,
    input  logic           AD_OUT_VALID,
    input  logic [N-1:0]   AD_A_X,
    input  logic [N-1:0]   AD_A_Z,
    input  logic [N-1:0]   AD_D_X,
    input  logic [N-1:0]   AD_D_Z
);

    localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [ST_W-1:0]  r_state_q,  w_state_d;
    logic [K_W-1:0]   r_k_q,      w_k_d;
    logic [CNT_W-1:0] r_idx_q,    w_idx_d;
    logic [TMO_W-1:0] r_tmo_q,    w_tmo_d;
    logic [N-1:0]     r_x1_q,     w_x1_d;
    logic [N-1:0]     r_z1_q,     w_z1_d;
    logic [N-1:0]     r_x2_q,     w_x2_d;
    logic [N-1:0]     r_z2_q,     w_z2_d;
    logic [N-1:0]     r_p1x_q,    w_p1x_d;
    logic [N-1:0]     r_p1z_q,    w_p1z_d;
    logic [N-1:0]     r_p2x_q,    w_p2x_d;
    logic [N-1:0]     r_p2z_q,    w_p2z_d;
    logic             r_b_q,      w_b_d;
    logic             r_inv_q,    w_inv_d;
    logic             r_busy_q,   w_busy_d;
    logic             r_done_q,   w_done_d;
    logic             r_zero_q,   w_zero_d;
    logic             r_error_q,  w_error_d;

    logic             w_idx_zero;
    logic             w_tmo_last;
    logic             w_b_next;
    logic [N-1:0]     w_op_p1x, w_op_p1z, w_op_p2x, w_op_p2z;
    logic [N-1:0]     w_wb_x1,  w_wb_z1,  w_wb_x2,  w_wb_z2;

    assign w_idx_zero = (r_idx_q == '0);
    assign w_tmo_last = (r_tmo_q == TMO_W'(TIMEOUT - 1));

    // ISSUE is only ever entered on a cycle that also shifts k left by one,
    // so the bit that will sit at the MSB during ISSUE is the current MSB-1.
    // Taking it straight from the register keeps the operand mux off the
    // next-state logic.
    assign w_b_next = r_k_q[K_W-2];

    // Operand routing: b=1 -> P1=(X1,Z1), P2=(X2,Z2); b=0 swapped.
    ladder_swap #(.W(N)) u_swap_op (
        .i_sel (w_b_next),
        .i_a_x (r_x1_q),
        .i_a_z (r_z1_q),
        .i_b_x (r_x2_q),
        .i_b_z (r_z2_q),
        .o_p_x (w_op_p1x),
        .o_p_z (w_op_p1z),
        .o_q_x (w_op_p2x),
        .o_q_z (w_op_p2z)
    );

    // Result write-back: b=1 -> (X1,Z1)=A, (X2,Z2)=D; b=0 swapped.
    ladder_swap #(.W(N)) u_swap_wb (
        .i_sel (r_b_q),
        .i_a_x (AD_A_X),
        .i_a_z (AD_A_Z),
        .i_b_x (AD_D_X),
        .i_b_z (AD_D_Z),
        .o_p_x (w_wb_x1),
        .o_p_z (w_wb_z1),
        .o_q_x (w_wb_x2),
        .o_q_z (w_wb_z2)
    );

    // ------------------------------------------------------------------
    // State register (and all other flops)
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state_q <= ST_IDLE;
            r_k_q     <= '0;
            r_idx_q   <= '0;
            r_tmo_q   <= '0;
            r_x1_q    <= '0;
            r_z1_q    <= '0;
            r_x2_q    <= '0;
            r_z2_q    <= '0;
            r_p1x_q   <= '0;
            r_p1z_q   <= '0;
            r_p2x_q   <= '0;
            r_p2z_q   <= '0;
            r_b_q     <= 1'b0;
            r_inv_q   <= 1'b0;
            r_busy_q  <= 1'b0;
            r_done_q  <= 1'b0;
            r_zero_q  <= 1'b0;
            r_error_q <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_k_q     <= w_k_d;
            r_idx_q   <= w_idx_d;
            r_tmo_q   <= w_tmo_d;
            r_x1_q    <= w_x1_d;
            r_z1_q    <= w_z1_d;
            r_x2_q    <= w_x2_d;
            r_z2_q    <= w_z2_d;
            r_p1x_q   <= w_p1x_d;
            r_p1z_q   <= w_p1z_d;
            r_p2x_q   <= w_p2x_d;
            r_p2z_q   <= w_p2z_d;
            r_b_q     <= w_b_d;
            r_inv_q   <= w_inv_d;
            r_busy_q  <= w_busy_d;
            r_done_q  <= w_done_d;
            r_zero_q  <= w_zero_d;
            r_error_q <= w_error_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_d = r_state_q;
        case (r_state_q)
            ST_IDLE:   if (START) w_state_d = ST_SCAN;
            ST_SCAN: begin
                if (r_k_q[K_W-1])   w_state_d = w_idx_zero ? ST_FINISH : ST_ISSUE;
                else if (w_idx_zero) w_state_d = ST_FINISH;
            end
            ST_ISSUE:  w_state_d = ST_GUARD;
            ST_GUARD:  w_state_d = ST_WAIT;
            ST_WAIT: begin
                if (AD_OUT_VALID)    w_state_d = ST_NEXT;
                else if (w_tmo_last) w_state_d = ST_FINISH;
            end
            ST_NEXT:   w_state_d = w_idx_zero ? ST_FINISH : ST_ISSUE;
            ST_FINISH: w_state_d = ST_IDLE;
            default:   w_state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath / output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_k_d     = r_k_q;
        w_idx_d   = r_idx_q;
        w_tmo_d   = r_tmo_q;
        w_x1_d    = r_x1_q;
        w_z1_d    = r_z1_q;
        w_x2_d    = r_x2_q;
        w_z2_d    = r_z2_q;
        w_p1x_d   = r_p1x_q;
        w_p1z_d   = r_p1z_q;
        w_p2x_d   = r_p2x_q;
        w_p2z_d   = r_p2z_q;
        w_b_d     = r_b_q;
        w_zero_d  = r_zero_q;
        w_error_d = r_error_q;

        case (r_state_q)
            ST_IDLE: begin
                if (START) begin
                    w_k_d     = DIN_K;
                    w_idx_d   = CNT_W'(K_W - 1);
                    w_x1_d    = DIN_X1;
                    w_z1_d    = DIN_Z1;
                    w_x2_d    = DIN_X2;
                    w_z2_d    = DIN_Z2;
                    w_zero_d  = 1'b0;
                    w_error_d = 1'b0;
                end
            end
            ST_SCAN: begin
                if (r_k_q[K_W-1]) begin
                    // Leading one is consumed without a step.
                    w_k_d = r_k_q << 1;
                    if (!w_idx_zero) w_idx_d = r_idx_q - CNT_W'(1);
                end else if (w_idx_zero) begin
                    w_zero_d = 1'b1;
                end else begin
                    w_k_d   = r_k_q << 1;
                    w_idx_d = r_idx_q - CNT_W'(1);
                end
            end
            ST_ISSUE: begin
                w_tmo_d = '0;
            end
            ST_WAIT: begin
                if (AD_OUT_VALID) begin
                    w_x1_d = w_wb_x1;
                    w_z1_d = w_wb_z1;
                    w_x2_d = w_wb_x2;
                    w_z2_d = w_wb_z2;
                end else if (w_tmo_last) begin
                    w_error_d = 1'b1;
                end else begin
                    w_tmo_d = r_tmo_q + TMO_W'(1);
                end
            end
            ST_NEXT: begin
                if (!w_idx_zero) begin
                    w_k_d   = r_k_q << 1;
                    w_idx_d = r_idx_q - CNT_W'(1);
                end
            end
            default: ;
        endcase

        // Operands and the step key are latched on entry to ISSUE and then
        // held, so they stay stable until the result is written back.
        w_inv_d = (w_state_d == ST_ISSUE);
        if (w_state_d == ST_ISSUE) begin
            w_b_d   = w_b_next;
            w_p1x_d = w_op_p1x;
            w_p1z_d = w_op_p1z;
            w_p2x_d = w_op_p2x;
            w_p2z_d = w_op_p2z;
        end

        w_busy_d = (w_state_d != ST_IDLE) && (w_state_d != ST_FINISH);
        w_done_d = (w_state_d == ST_FINISH);
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign BUSY        = r_busy_q;
    assign DONE        = r_done_q;
    assign ZERO        = r_zero_q;
    assign ERROR       = r_error_q;
    assign DOUT_X1     = r_x1_q;
    assign DOUT_Z1     = r_z1_q;
    assign DOUT_X2     = r_x2_q;
    assign DOUT_Z2     = r_z2_q;
    assign AD_IN_VALID = r_inv_q;
    assign AD_P1_X     = r_p1x_q;
    assign AD_P1_Z     = r_p1z_q;
    assign AD_P2_X     = r_p2x_q;
    assign AD_P2_Z     = r_p2z_q;

endmodule : ladder_ctrl
`default_nettype wire
